// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: instruction-memory request/response pins plus the
// valid/ready instruction stream toward decode.
interface inst_fetch_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 20
);
  logic              mem_enable;
  logic              mem_read_writenot;
  logic [ADDR_W-1:0] mem_read_address;
  logic [DATA_W-1:0] mem_out_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output mem_enable, mem_read_writenot, mem_read_address,
    input  mem_out_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  mem_enable, mem_read_writenot, mem_read_address,
    output mem_out_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch initiator: issues sequential reads to the instruction
// memory, buffers responses in a small FIFO and hands them to decode in order.
module inst_fetch #(
  parameter int          ADDR_W   = 5,
  parameter int          DATA_W   = 20,
  parameter int          DEPTH    = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  inst_fetch_if.master      bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];

  logic              valid;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CW:0]       credit_used;
  logic [CW:0]       credit_limit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit compares count+inflight against DEPTH+pop so no subtraction can underflow.
  always_comb begin
    valid        = (count != '0);
    pop          = valid & bus.inst_ready & ~redirect;
    push         = inflight & ~redirect;
    credit_used  = (CW+1)'(count) + (CW+1)'(inflight);
    credit_limit = (CW+1)'(DEPTH) + (CW+1)'(pop);
    issue        = rst & fetch_en & ~redirect & (credit_used < credit_limit);
  end

  assign bus.mem_enable        = issue;
  assign bus.mem_read_writenot = 1'b1;
  assign bus.mem_read_address  = pc;
  assign bus.inst_valid        = valid;
  assign bus.inst_data         = valid ? fifo_data[rd_ptr] : '0;
  assign bus.inst_pc           = valid ? fifo_pc[rd_ptr]   : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= ADDR_W'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect) begin
      pc       <= redirect_addr;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + ADDR_W'(1);
        inflight_pc <= pc;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.mem_out_data;
      fifo_pc[wr_ptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: memory model, in-order scoreboard of expected
// instruction addresses, and cycle-exact checks of latency, stall and redirect.
module tb_inst_fetch;
  localparam int          ADDR_W   = 5;
  localparam int          DATA_W   = 20;
  localparam int          DEPTH    = 2;
  localparam int unsigned RESET_PC = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fetch_en = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_addr = '0;

  inst_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  inst_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_addr(redirect_addr), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [32];
  logic [ADDR_W-1:0] sb_q [$];
  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [ADDR_W-1:0] start, input int n);
    sb_q.delete();
    for (int i = 0; i < n; i++) sb_q.push_back(start + ADDR_W'(i));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory: registered read, updated on the edge that samples a request.
  always @(posedge clk)
    if (bus.mem_enable) bus.mem_out_data <= mem[bus.mem_read_address];

  // Scoreboard: every accepted instruction must be the next expected address.
  always @(negedge clk) begin
    if (rst && !redirect && bus.inst_valid && bus.inst_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 32'(bus.inst_pc), 32'hFFFF_FFFF);
      end else begin
        logic [ADDR_W-1:0] exp_pc;
        exp_pc = sb_q.pop_front();
        check("sb_pc", 32'(bus.inst_pc), 32'(exp_pc));
        check("sb_data", 32'(bus.inst_data), 32'h100 + 32'(exp_pc));
      end
      pops++;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 20'h100 + 20'(i);
    bus.inst_ready = 1'b1;
    #1 rst = 1'b0;
    fetch_en = 1'b1;
    #1;
    check("rst_valid", 32'(bus.inst_valid), 0);
    check("rst_data", 32'(bus.inst_data), 0);
    check("rst_pc", 32'(bus.inst_pc), 0);
    check("rst_men", 32'(bus.mem_enable), 0);
    check("rst_rwn", 32'(bus.mem_read_writenot), 1);

    // Boot: first instruction two cycles after the first request.
    cyc(2);
    sb_load(ADDR_W'(RESET_PC), 40);
    pops = 0;
    rst = 1'b1;
    @(negedge clk);
    check("boot_men", 32'(bus.mem_enable), 1);
    check("boot_addr", 32'(bus.mem_read_address), RESET_PC);
    @(negedge clk);
    check("boot_lat", 32'(bus.inst_valid), 0);
    @(negedge clk);
    check("boot_valid", 32'(bus.inst_valid), 1);
    check("boot_pc", 32'(bus.inst_pc), 0);
    check("boot_data", 32'(bus.inst_data), 32'h100);
    cyc(10);
    check("boot_rate", 32'(pops), 10);

    // Redirect to 30 and run across the 31 -> 0 wrap.
    redirect = 1'b1; redirect_addr = 5'd30;
    sb_load(5'd30, 40);
    pops = 0;
    @(negedge clk);
    check("redir_noissue", 32'(bus.mem_enable), 0);
    cyc(1);
    redirect = 1'b0;
    @(negedge clk);
    check("wrap_addr", 32'(bus.mem_read_address), 30);
    check("wrap_men", 32'(bus.mem_enable), 1);
    cyc(8);
    check("wrap_rate", 32'(pops), 6);

    // Stall decode for 5 cycles; head is pc 4.
    bus.inst_ready = 1'b0;
    pops = 0;
    @(negedge clk);
    check("stall_men", 32'(bus.mem_enable), 0);
    check("stall_valid", 32'(bus.inst_valid), 1);
    check("stall_pc", 32'(bus.inst_pc), 4);
    cyc(4);
    check("hold_pops", 32'(pops), 0);
    @(negedge clk);
    check("hold_pc", 32'(bus.inst_pc), 4);
    check("hold_men", 32'(bus.mem_enable), 0);
    cyc(1);
    bus.inst_ready = 1'b1;
    cyc(5);
    check("drain_rate", 32'(pops), 5);

    // Redirect to 0x14 with the buffer at full credit.
    bus.inst_ready = 1'b0;
    redirect = 1'b1; redirect_addr = 5'h14;
    sb_load(5'h14, 40);
    pops = 0;
    @(negedge clk);
    check("flush_men", 32'(bus.mem_enable), 0);
    cyc(1);
    redirect = 1'b0;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    check("flush_valid1", 32'(bus.inst_valid), 0);
    check("flush_addr", 32'(bus.mem_read_address), 32'h14);
    check("flush_men1", 32'(bus.mem_enable), 1);
    @(negedge clk);
    check("flush_valid2", 32'(bus.inst_valid), 0);
    @(negedge clk);
    check("flush_valid3", 32'(bus.inst_valid), 1);
    check("flush_pc", 32'(bus.inst_pc), 32'h14);
    check("flush_data", 32'(bus.inst_data), 32'h114);
    cyc(1);
    check("flush_pops", 32'(pops), 1);

    // Redirect with pop in the same cycle, then a second redirect to 0x05.
    redirect = 1'b1; redirect_addr = 5'h0A;
    sb_load(5'h0A, 40);
    cyc(1);
    check("dbl_pop_ignored", 32'(pops), 1);
    redirect_addr = 5'h05;
    sb_load(5'h05, 40);
    @(negedge clk);
    check("dbl_valid", 32'(bus.inst_valid), 0);
    check("dbl_men", 32'(bus.mem_enable), 0);
    cyc(1);
    redirect = 1'b0;
    @(negedge clk);
    check("dbl_addr", 32'(bus.mem_read_address), 5);
    check("dbl_men2", 32'(bus.mem_enable), 1);
    @(negedge clk);
    check("dbl_lat", 32'(bus.inst_valid), 0);
    @(negedge clk);
    check("dbl_valid2", 32'(bus.inst_valid), 1);
    check("dbl_pc", 32'(bus.inst_pc), 5);
    check("dbl_data", 32'(bus.inst_data), 32'h105);

    // Fill two entries, then reset mid-stream.
    cyc(1);
    bus.inst_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_pc", 32'(bus.inst_pc), 6);
    cyc(1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.inst_valid), 0);
    check("mid_rst_men", 32'(bus.mem_enable), 0);
    check("mid_rst_addr", 32'(bus.mem_read_address), RESET_PC);
    @(negedge clk);
    check("mid_rst_pc", 32'(bus.inst_pc), 0);
    check("mid_rst_data", 32'(bus.inst_data), 0);
    sb_load(ADDR_W'(RESET_PC), 40);
    pops = 0;
    cyc(2);
    rst = 1'b1;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    check("restart_addr", 32'(bus.mem_read_address), RESET_PC);
    check("restart_men", 32'(bus.mem_enable), 1);
    cyc(8);
    check("restart_rate", 32'(pops), 6);

    // fetch_en low: outstanding response captured, FIFO drains, pc holds.
    fetch_en = 1'b0;
    pops = 0;
    @(negedge clk);
    check("fen_men", 32'(bus.mem_enable), 0);
    @(negedge clk);
    check("fen_capture_valid", 32'(bus.inst_valid), 1);
    check("fen_capture_pc", 32'(bus.inst_pc), 7);
    @(negedge clk);
    check("fen_empty", 32'(bus.inst_valid), 0);
    cyc(2);
    fetch_en = 1'b1;
    @(negedge clk);
    check("fen_resume_addr", 32'(bus.mem_read_address), 8);
    check("fen_resume_men", 32'(bus.mem_enable), 1);
    cyc(4);
    check("fen_pops", 32'(pops), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
